// File: rtl/rr_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb_pkg                                                    |
// | Purpose  : Shared sizes, FSM state encoding and small index helpers for  |
// |            the three-way round-robin arbiter (rr_arb3 / rr_pick3).       |
// | Contents : N_REQ, ID_W, c_IDLE / c_OWN, onehot3(), idx_next()            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package rr_arb_pkg;

    localparam int N_REQ = 3;
    localparam int ID_W  = 2;

    // Arbiter FSM encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_OWN  = 1'b1;

    // Requester index -> one-hot grant vector; out-of-range index gives zero.
    function automatic logic [N_REQ-1:0] onehot3(input logic [ID_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Modulo-3 increment: 0->1->2->0
    function automatic logic [ID_W-1:0] idx_next(input logic [ID_W-1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick3                                                      |
// | Purpose  : Combinational rotating-priority picker. Returns the first     |
// |            requester found scanning i_pri, i_pri+1, i_pri+2 (mod 3),     |
// |            optionally excluding one index.                               |
// | Ports    : i_req      [3] request vector                                 |
// |            i_pri      [2] index scanned first                            |
// |            i_mask_idx [2] index excluded from the scan when i_mask_en=1  |
// |            i_mask_en  [1] enable the exclusion                           |
// |            o_found    [1] some eligible requester exists                 |
// |            o_idx      [2] chosen index (0 when o_found=0)                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_pick3
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_pri,
    input  logic [ID_W-1:0]  i_mask_idx,
    input  logic             i_mask_en,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    logic [N_REQ-1:0] w_elig;
    logic [ID_W-1:0]  w_cand;

    assign w_elig = i_req & ~(i_mask_en ? onehot3(i_mask_idx) : {N_REQ{1'b0}});

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = i_pri;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_found && w_elig[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
            w_cand = idx_next(w_cand);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb3                                                       |
// | Purpose  : Round-robin arbiter sharing one resource among three          |
// |            requesters. Registered one-hot grant; the owner keeps the     |
// |            grant while requesting, limited to MAX_HOLD consecutive       |
// |            cycles when others are waiting (0 = no limit).                |
// | Params   : MAX_HOLD - hold limit before forced handover (0 = unlimited)  |
// |            CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD            |
// | Ports    : CK      in  [1] clock, rising edge                            |
// |            RN      in  [1] asynchronous active-low reset                 |
// |            REQ     in  [3] level requests, bit i = requester i           |
// |            GNT     out [3] registered one-hot (or zero) grant            |
// |            GNT_ID  out [2] owner index, meaningful while BUSY=1          |
// |            BUSY    out [1] any grant bit set                             |
// |            PREEMPT out [1] one-cycle pulse on a forced handover          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_arb3
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
)(
    input  logic             CK,
    input  logic             RN,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [ID_W-1:0]  GNT_ID,
    output logic             BUSY,
    output logic             PREEMPT
);

    // Counter stops at the hold limit; with no limit it parks at all-ones.
    localparam logic [CNT_W-1:0] c_CNT_SAT =
        (MAX_HOLD != 0) ? CNT_W'(MAX_HOLD) : {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_pri;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic             r_busy;
    logic             r_preempt;

    logic             w_own_req;
    logic             w_others;
    logic             w_release;
    logic             w_preempt;
    logic             w_handover;
    logic [ID_W-1:0]  w_pick_pri;
    logic             w_found;
    logic [ID_W-1:0]  w_pick;

    assign w_own_req  = REQ[r_gnt_id];
    assign w_others   = |(REQ & ~onehot3(r_gnt_id));
    assign w_release  = (r_state == c_OWN) && !w_own_req;
    assign w_preempt  = (r_state == c_OWN) && w_own_req && (MAX_HOLD != 0) &&
                        (r_cnt == c_CNT_SAT) && w_others;
    assign w_handover = w_release || w_preempt;

    // On any handover the scan restarts just past the outgoing owner and the
    // outgoing owner is masked, so it cannot win back a preemption.
    assign w_pick_pri = w_handover ? idx_next(r_gnt_id) : r_pri;

    rr_pick3 u_pick (
        .i_req      (REQ),
        .i_pri      (w_pick_pri),
        .i_mask_idx (r_gnt_id),
        .i_mask_en  (w_handover),
        .o_found    (w_found),
        .o_idx      (w_pick)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state   <= c_IDLE;
            r_pri     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_preempt;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state  <= c_OWN;
                        r_gnt    <= onehot3(w_pick);
                        r_gnt_id <= w_pick;
                        r_busy   <= 1'b1;
                        r_cnt    <= CNT_W'(1);
                    end
                end
                c_OWN: begin
                    if (w_handover) begin
                        r_pri <= w_pick_pri;
                        if (w_found) begin
                            r_gnt    <= onehot3(w_pick);
                            r_gnt_id <= w_pick;
                            r_cnt    <= CNT_W'(1);
                        end else begin
                            r_state <= c_IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end else if (r_cnt != c_CNT_SAT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign GNT     = r_gnt;
    assign GNT_ID  = r_gnt_id;
    assign BUSY    = r_busy;
    assign PREEMPT = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb3.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rr_arb3                                                    |
// | Purpose  : Self-checking bench for rr_arb3. Two instances share stimulus:|
// |            one with MAX_HOLD=8, one with MAX_HOLD=0 (unlimited).         |
// |            Each is compared every cycle against an integer-level         |
// |            reference model, plus table vectors and directed sequences.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rr_arb3;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [2:0] REQ = 3'b000;

    logic [2:0] gnt8, gnt0;
    logic [1:0] id8, id0;
    logic       busy8, busy0, pre8, pre0;

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    rr_arb3 #(.MAX_HOLD(8), .CNT_W(4)) dut_h8 (
        .CK(CK), .RN(RN), .REQ(REQ),
        .GNT(gnt8), .GNT_ID(id8), .BUSY(busy8), .PREEMPT(pre8)
    );

    rr_arb3 #(.MAX_HOLD(0), .CNT_W(4)) dut_h0 (
        .CK(CK), .RN(RN), .REQ(REQ),
        .GNT(gnt0), .GNT_ID(id0), .BUSY(busy0), .PREEMPT(pre0)
    );

    // ---------------- reference model (owner as an int, -1 = none) --------
    typedef struct {
        int owner;
        int pri;
        int hold;
        bit pre;
    } mst_t;

    mst_t m8, m0;

    function automatic mst_t m_reset();
        mst_t s;
        s.owner = -1; s.pri = 0; s.hold = 0; s.pre = 1'b0;
        return s;
    endfunction

    function automatic int scan(input logic [2:0] req, input int from, input int skip);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (from + k) % 3;
            if (req[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic mst_t m_step(input mst_t s, input logic [2:0] req, input int max_hold);
        mst_t n;
        n = s;
        n.pre = 1'b0;
        if (s.owner < 0) begin
            n.owner = scan(req, s.pri, -1);
            n.hold  = (n.owner >= 0) ? 1 : 0;
        end else if (!req[s.owner]) begin
            n.pri   = (s.owner + 1) % 3;
            n.owner = scan(req, n.pri, s.owner);
            n.hold  = (n.owner >= 0) ? 1 : 0;
        end else if (max_hold != 0 && s.hold >= max_hold &&
                     (req & ~(3'b001 << s.owner)) != 3'b000) begin
            n.pri   = (s.owner + 1) % 3;
            n.owner = scan(req, n.pri, s.owner);
            n.hold  = 1;
            n.pre   = 1'b1;
        end else begin
            n.hold = s.hold + 1;
        end
        return n;
    endfunction

    function automatic logic [2:0] m_gnt(input mst_t s);
        logic [2:0] g;
        g = 3'b000;
        if (s.owner >= 0) g[s.owner] = 1'b1;
        return g;
    endfunction

    // ---------------- checking helpers ------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string name, input logic [2:0] g, input logic [1:0] id,
                             input logic b, input logic p, input mst_t s, input logic [2:0] req);
        chk({name, ".gnt"},     32'(g), 32'(m_gnt(s)));
        chk({name, ".busy"},    32'(b), 32'(s.owner >= 0));
        chk({name, ".preempt"}, 32'(p), 32'(s.pre));
        if (s.owner >= 0) chk({name, ".gnt_id"}, 32'(id), 32'(s.owner));
        chk({name, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        chk({name, ".busy_or"}, 32'(b), 32'(|g));
        chk({name, ".no_idle_gnt"}, 32'(g & ~req), 32'd0);
    endtask

    // Drive one cycle: inputs applied 1ns after an edge, outputs sampled 1ns
    // after the next edge.
    task automatic step(input logic rn, input logic [2:0] req);
        RN  = rn;
        REQ = req;
        @(posedge CK);
        if (!rn) begin
            m8 = m_reset();
            m0 = m_reset();
        end else begin
            m8 = m_step(m8, req, 8);
            m0 = m_step(m0, req, 0);
        end
        #1;
        check_dut("h8", gnt8, id8, busy8, pre8, m8, req);
        check_dut("h0", gnt0, id0, busy0, pre0, m0, req);
    endtask

    // ---------------- table vectors ---------------------------------------
    typedef struct {
        logic       rn;
        logic [2:0] req;
        logic [2:0] gnt;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [2:0] cur;
        logic       rn;

        m8 = m_reset();
        m0 = m_reset();

        tbl[0] = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b0}; // held in reset
        tbl[1] = '{1'b1, 3'b111, 3'b001, 1'b1, 1'b0}; // first edge out of reset
        tbl[2] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 3'b110, 3'b010, 1'b1, 1'b0}; // PRI=0 skips idle 0
        tbl[4] = '{1'b1, 3'b100, 3'b100, 1'b1, 1'b0}; // release, no bubble
        tbl[5] = '{1'b1, 3'b101, 3'b100, 1'b1, 1'b0}; // owner 2 keeps
        tbl[6] = '{1'b1, 3'b001, 3'b001, 1'b1, 1'b0}; // PRI wraps to 0
        tbl[7] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0}; // release to idle
        tbl[8] = '{1'b1, 3'b011, 3'b010, 1'b1, 1'b0}; // PRI=1 now
        tbl[9] = '{1'b1, 3'b001, 3'b001, 1'b1, 1'b0}; // scan 2,0

        for (int v = 0; v < 10; v++) begin
            step(tbl[v].rn, tbl[v].req);
            chk($sformatf("tbl%0d.h8.gnt", v),  32'(gnt8),  32'(tbl[v].gnt));
            chk($sformatf("tbl%0d.h8.busy", v), 32'(busy8), 32'(tbl[v].busy));
            chk($sformatf("tbl%0d.h8.pre", v),  32'(pre8),  32'(tbl[v].pre));
            chk($sformatf("tbl%0d.h0.gnt", v),  32'(gnt0),  32'(tbl[v].gnt));
        end

        // Hold limit: requester 0 owns 8 cycles, then a one-cycle PREEMPT
        // hands over to 1; the unlimited instance never lets go.
        step(1'b0, 3'b000);
        step(1'b1, 3'b000);
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 3'b011);
            chk($sformatf("hold%0d.h8.gnt", c), 32'(gnt8), (c < 8) ? 32'd1 : 32'd2);
            chk($sformatf("hold%0d.h8.pre", c), 32'(pre8), (c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("hold%0d.h0.gnt", c), 32'(gnt0), 32'd1);
            chk($sformatf("hold%0d.h0.pre", c), 32'(pre0), 32'd0);
        end

        // Lone requester never preempted.
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 3'b100);
            chk($sformatf("solo%0d.h8.gnt", c), 32'(gnt8), 32'd4);
            chk($sformatf("solo%0d.h8.pre", c), 32'(pre8), 32'd0);
            chk($sformatf("solo%0d.h0.gnt", c), 32'(gnt0), 32'd4);
        end

        // Asynchronous reset mid-grant, then PRI must be back at 0.
        RN = 1'b0;
        #2;
        chk("async.h8.gnt",  32'(gnt8),  32'd0);
        chk("async.h8.busy", 32'(busy8), 32'd0);
        chk("async.h0.gnt",  32'(gnt0),  32'd0);
        m8 = m_reset();
        m0 = m_reset();
        step(1'b1, 3'b110);
        chk("post_rst.h8.gnt", 32'(gnt8), 32'd2);
        chk("post_rst.h0.gnt", 32'(gnt0), 32'd2);

        // Random traffic with long-ish stable stretches so hold limits trigger.
        cur = 3'b000;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) cur = 3'($urandom_range(0, 7));
            rn = ($urandom_range(0, 299) != 0);
            step(rn, cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
